// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//   fetch_state_e : fetch FSM states
//   DEF_ADDR_W    : default PC / memory address width
//   DEF_DATA_W    : default instruction width
//   WDOG_W        : watchdog counter width
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int WDOG_W     = 8;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - cycle counter flagging a memory request that is never acknowledged
//   clock   in  : system clock
//   clear_n in  : asynchronous active-low reset
//   clear   in  : zero the count (takes priority over enable)
//   enable  in  : count one more unacknowledged request cycle
//   expired out : count has reached TIMEOUT-1
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic clear_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: reads memory at the PC, holds the word for decode
//   clock     in  : system clock
//   clear_n   in  : asynchronous active-low reset
//   run       in  : fetch enable from control
//   address   in  : current PC value
//   pc_up     out : one-cycle PC increment request
//   mem_req   out : instruction memory read request
//   mem_addr  out : read address (equals address)
//   mem_ack   in  : memory read complete, mem_rdata valid
//   mem_rdata in  : instruction word
//   ir        out : instruction register
//   ir_addr   out : address ir was fetched from
//   ir_valid  out : ir holds an unconsumed instruction
//   ir_ready  in  : decode accepts ir this cycle
//   fetch_err out : sticky watchdog error
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] address,
    output logic              pc_up,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         capture;
    logic         wd_clear;
    logic         wd_enable;
    logic         wd_expired;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ir_ready) begin
                    state_d = run ? ST_REQ : ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Zero the watchdog on every entry into REQ so each request gets a full budget.
    assign wd_clear = (state_d == ST_REQ) && (state_q != ST_REQ);

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .clear_n (clear_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ir      <= '0;
            ir_addr <= '0;
        end else if (capture) begin
            ir      <= mem_rdata;
            ir_addr <= address;
        end
    end

    // Outputs decode the state register directly, so the async reset clears
    // them immediately and ir_ready never reaches mem_req combinationally.
    assign mem_req   = (state_q == ST_REQ);
    assign pc_up     = mem_req && mem_ack;
    assign ir_valid  = (state_q == ST_HOLD);
    assign fetch_err = (state_q == ST_ERR);
    assign mem_addr  = address;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table-driven bench for instruction_fetch
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        run;
    logic        ir_ready;
    logic [3:0]  wait_n;
    logic        stray;
    logic [15:0] pc;
    logic [3:0]  wcnt;
    logic        pc_up, mem_req, mem_ack, ir_valid, fetch_err;
    logic [15:0] mem_addr, mem_rdata, ir, ir_addr;

    logic        run4, ack4, ready4;
    logic [15:0] addr4  = 16'h0040;
    logic [15:0] rdata4 = 16'h1234;
    logic        pc_up4, mem_req4, ir_valid4, fetch_err4;
    logic [15:0] mem_addr4, ir4, ir_addr4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
        .clock(clock), .clear_n(clear_n), .run(run), .address(pc),
        .pc_up(pc_up), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_addr(ir_addr),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_err(fetch_err)
    );

    instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut4 (
        .clock(clock), .clear_n(clear_n), .run(run4), .address(addr4),
        .pc_up(pc_up4), .mem_req(mem_req4), .mem_addr(mem_addr4),
        .mem_ack(ack4), .mem_rdata(rdata4), .ir(ir4), .ir_addr(ir_addr4),
        .ir_valid(ir_valid4), .ir_ready(ready4), .fetch_err(fetch_err4)
    );

    // Program counter (+4 per pc_up) and a memory that acks after wait_n cycles.
    assign mem_ack   = stray | (mem_req && (wcnt >= wait_n));
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc   <= 16'h0000;
            wcnt <= 4'd0;
        end else begin
            if (pc_up) pc <= pc + 16'd4;
            wcnt <= (mem_req && !mem_ack) ? wcnt + 4'd1 : 4'd0;
        end
    end

    typedef struct {
        logic        run;
        logic        rdy;
        logic [3:0]  wt;
        logic        stray;
        logic        req;
        logic        up;
        logic        vld;
        logic        err;
        logic [15:0] ir;
        logic [15:0] ira;
        logic [15:0] maddr;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        //            run rdy wt stray req up vld err  ir        ira       maddr
        tbl[0]  = '{1'b1,1'b0,4'd0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,16'h0000};
        tbl[1]  = '{1'b1,1'b0,4'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'h0000,16'h0000,16'h0000};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{1'b1,1'b0,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5A5,16'h0000,16'h0004};
        tbl[7]  = '{1'b1,1'b1,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5A5,16'h0000,16'h0004};
        tbl[8]  = '{1'b1,1'b1,4'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'hA5A5,16'h0000,16'h0004};
        tbl[9]  = '{1'b1,1'b1,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5A1,16'h0004,16'h0008};
        tbl[10] = '{1'b1,1'b1,4'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'hA5A1,16'h0004,16'h0008};
        tbl[11] = '{1'b1,1'b1,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5AD,16'h0008,16'h000C};
        tbl[12] = '{1'b1,1'b1,4'd0,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'hA5AD,16'h0008,16'h000C};
        tbl[13] = '{1'b1,1'b1,4'd3,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5A9,16'h000C,16'h0010};
        for (int i = 14; i <= 16; i++)
            tbl[i] = '{1'b1,1'b1,4'd3,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'hA5A9,16'h000C,16'h0010};
        tbl[17] = '{1'b1,1'b1,4'd3,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'hA5A9,16'h000C,16'h0010};
        tbl[18] = '{1'b1,1'b1,4'd2,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5B5,16'h0010,16'h0014};
        tbl[19] = '{1'b0,1'b1,4'd2,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'hA5B5,16'h0010,16'h0014};
        tbl[20] = '{1'b0,1'b1,4'd2,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'hA5B5,16'h0010,16'h0014};
        tbl[21] = '{1'b0,1'b0,4'd2,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'hA5B5,16'h0010,16'h0014};
        tbl[22] = '{1'b0,1'b0,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5B1,16'h0014,16'h0018};
        tbl[23] = '{1'b0,1'b1,4'd0,1'b0, 1'b0,1'b0,1'b1,1'b0, 16'hA5B1,16'h0014,16'h0018};
        tbl[24] = '{1'b0,1'b1,4'd0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'hA5B1,16'h0014,16'h0018};
        tbl[25] = '{1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'hA5B1,16'h0014,16'h0018};
        tbl[26] = '{1'b0,1'b0,4'd0,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'hA5B1,16'h0014,16'h0018};
        tbl[27] = '{1'b0,1'b0,4'd0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'hA5B1,16'h0014,16'h0018};

        // Reset held with run=1: everything at its reset value.
        clear_n = 1'b0; run = 1'b1; ir_ready = 1'b0; wait_n = 4'd0; stray = 1'b0;
        run4 = 1'b0; ack4 = 1'b0; ready4 = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst.mem_req",   {15'd0, mem_req},   16'h0);
        chk("rst.pc_up",     {15'd0, pc_up},     16'h0);
        chk("rst.ir_valid",  {15'd0, ir_valid},  16'h0);
        chk("rst.fetch_err", {15'd0, fetch_err}, 16'h0);
        chk("rst.ir",        ir,      16'h0000);
        chk("rst.ir_addr",   ir_addr, 16'h0000);
        @(posedge clock); #1;
        clear_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            run = tbl[i].run; ir_ready = tbl[i].rdy; wait_n = tbl[i].wt; stray = tbl[i].stray;
            @(negedge clock);
            chk($sformatf("v%0d.mem_req", i),   {15'd0, mem_req},   {15'd0, tbl[i].req});
            chk($sformatf("v%0d.pc_up", i),     {15'd0, pc_up},     {15'd0, tbl[i].up});
            chk($sformatf("v%0d.ir_valid", i),  {15'd0, ir_valid},  {15'd0, tbl[i].vld});
            chk($sformatf("v%0d.fetch_err", i), {15'd0, fetch_err}, {15'd0, tbl[i].err});
            chk($sformatf("v%0d.ir", i),        ir,       tbl[i].ir);
            chk($sformatf("v%0d.ir_addr", i),   ir_addr,  tbl[i].ira);
            chk($sformatf("v%0d.mem_addr", i),  mem_addr, tbl[i].maddr);
            @(posedge clock); #1;
        end

        // Reset asserted mid-request: outputs drop before any clock edge.
        run = 1'b1; wait_n = 4'd5; stray = 1'b0;
        @(posedge clock); #1;
        stray = 1'b1;
        @(negedge clock);
        chk("midrst.pre_mem_req", {15'd0, mem_req}, 16'h1);
        chk("midrst.pre_pc_up",   {15'd0, pc_up},   16'h1);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst.mem_req",  {15'd0, mem_req},  16'h0);
        chk("midrst.pc_up",    {15'd0, pc_up},    16'h0);
        chk("midrst.ir_valid", {15'd0, ir_valid}, 16'h0);
        chk("midrst.ir",       ir,      16'h0000);
        chk("midrst.ir_addr",  ir_addr, 16'h0000);
        stray = 1'b0; run = 1'b0;
        @(posedge clock); #1;
        clear_n = 1'b1;
        @(negedge clock);
        chk("postrst.mem_req", {15'd0, mem_req}, 16'h0);

        // TIMEOUT=4: ack on the 4th REQ cycle still captures normally.
        @(posedge clock); #1;
        run4 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock); #1;
            ack4 = (i == 4);
            @(negedge clock);
            chk($sformatf("t4ack.c%0d.mem_req", i),   {15'd0, mem_req4},   16'h1);
            chk($sformatf("t4ack.c%0d.pc_up", i),     {15'd0, pc_up4},     {15'd0, (i == 4)});
            chk($sformatf("t4ack.c%0d.fetch_err", i), {15'd0, fetch_err4}, 16'h0);
        end
        @(posedge clock); #1;
        ack4 = 1'b0;
        @(negedge clock);
        chk("t4ack.ir_valid",  {15'd0, ir_valid4},  16'h1);
        chk("t4ack.fetch_err", {15'd0, fetch_err4}, 16'h0);
        chk("t4ack.ir",        ir4,      16'h1234);
        chk("t4ack.ir_addr",   ir_addr4, 16'h0040);
        ready4 = 1'b1;

        // TIMEOUT=4 with no ack: four REQ cycles, then sticky error.
        @(posedge clock); #1;
        ready4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            chk($sformatf("t4to.c%0d.mem_req", i),   {15'd0, mem_req4},   16'h1);
            chk($sformatf("t4to.c%0d.fetch_err", i), {15'd0, fetch_err4}, 16'h0);
            @(posedge clock); #1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk($sformatf("t4err%0d.fetch_err", i), {15'd0, fetch_err4}, 16'h1);
            chk($sformatf("t4err%0d.mem_req", i),   {15'd0, mem_req4},   16'h0);
            chk($sformatf("t4err%0d.ir_valid", i),  {15'd0, ir_valid4},  16'h0);
            @(posedge clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
